// File: rtl/conv1_row_sequencer.sv
// conv1_row_sequencer: walks every pooled row of every feature map in the
// interlayer buffer and streams the rows to conv layer 1 over a valid/ready
// handshake. A 2-entry skid FIFO absorbs the 1-cycle buffer read latency.
// Optional build macro CONV1_ZERO_PAD_EN: frames each feature with 2 zero rows
// above and 2 below. Pad rows use the same pipeline slot but never read the buffer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module conv1_row_sequencer #(
    parameter int INPUT_SIZE    = 12,
    parameter int TOTAL_FEATURE = 20,
    parameter int ADDR_WIDTH    = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             buf_rd,
    output logic [ADDR_WIDTH-1:0]            buf_addr,
    input  logic [INPUT_SIZE*`DATA_WIDTH-1:0] buf_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [INPUT_SIZE*`DATA_WIDTH-1:0] out_data,
    output logic [4:0]                       out_feature,
    output logic [4:0]                       out_row,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
);

    localparam int DW = INPUT_SIZE * `DATA_WIDTH;
`ifdef CONV1_ZERO_PAD_EN
    localparam int ROWS = INPUT_SIZE + 4;
    localparam logic [4:0] PAD_TOP_END = 5'd2;
    localparam logic [4:0] PAD_BOT_BEG = 5'(INPUT_SIZE + 2);
`else
    localparam int ROWS = INPUT_SIZE;
`endif
    localparam logic [4:0] ROW_LAST  = 5'(ROWS - 1);
    localparam logic [4:0] FEAT_LAST = 5'(TOTAL_FEATURE - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [4:0]            feat_q, feat_d;
    logic [4:0]            row_q, row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // One-deep in-flight slot: tags of the row whose data lands next cycle
    logic                  fly_q;
    logic [4:0]            fly_feat_q;
    logic [4:0]            fly_row_q;
    logic                  fly_last_q;
`ifdef CONV1_ZERO_PAD_EN
    logic                  fly_pad_q;
    logic                  is_pad;
`endif

    // 2-entry FIFO storage
    logic [DW-1:0]         fdata_q [2];
    logic [4:0]            ffeat_q [2];
    logic [4:0]            frow_q  [2];
    logic                  flast_q [2];
    logic                  wptr_q, rptr_q;
    logic [1:0]            cnt_q;

    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic [2:0]            used;

    assign pop        = out_valid && out_ready;
    assign last_issue = (feat_q == FEAT_LAST) && (row_q == ROW_LAST);
    // Room is judged after this cycle's departure so a full-rate stream never bubbles
    assign used       = {1'b0, cnt_q} + {2'b00, fly_q} - {2'b00, pop};
    assign issue      = (state_q == READ) && (used < 3'd2);

`ifdef CONV1_ZERO_PAD_EN
    assign is_pad = (row_q < PAD_TOP_END) || (row_q >= PAD_BOT_BEG);
    assign buf_rd = issue && !is_pad;
`else
    assign buf_rd = issue;
`endif
    assign buf_addr = addr_q;

    assign out_valid   = (cnt_q != 2'd0);
    assign out_data    = fdata_q[rptr_q];
    assign out_feature = ffeat_q[rptr_q];
    assign out_row     = frow_q[rptr_q];
    assign out_last    = flast_q[rptr_q];
    assign busy        = (state_q == READ) || (state_q == DRAIN);
    assign done        = (state_q == DONE);

    // Next-state and row/feature/address counter sequencing
    always_comb begin
        state_d = state_q;
        feat_d  = feat_q;
        row_d   = row_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    feat_d  = 5'd0;
                    row_d   = 5'd0;
                    addr_d  = '0;
                end
            end
            READ: begin
                if (issue) begin
                    if (buf_rd) addr_d = addr_q + 1'b1;
                    if (last_issue) begin
                        state_d = DRAIN;
                    end else if (row_q == ROW_LAST) begin
                        row_d  = 5'd0;
                        feat_d = feat_q + 5'd1;
                    end else begin
                        row_d = row_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and in-flight tag register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            feat_q     <= 5'd0;
            row_q      <= 5'd0;
            addr_q     <= '0;
            fly_q      <= 1'b0;
            fly_feat_q <= 5'd0;
            fly_row_q  <= 5'd0;
            fly_last_q <= 1'b0;
`ifdef CONV1_ZERO_PAD_EN
            fly_pad_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            feat_q  <= feat_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            fly_q   <= issue;
            if (issue) begin
                fly_feat_q <= feat_q;
                fly_row_q  <= row_q;
                fly_last_q <= last_issue;
`ifdef CONV1_ZERO_PAD_EN
                fly_pad_q  <= is_pad;
`endif
            end
        end
    end

    // FIFO: landing row written at wptr, head popped on handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fdata_q[i] <= '0;
                ffeat_q[i] <= 5'd0;
                frow_q[i]  <= 5'd0;
                flast_q[i] <= 1'b0;
            end
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (fly_q) begin
`ifdef CONV1_ZERO_PAD_EN
                fdata_q[wptr_q] <= fly_pad_q ? '0 : buf_data;
`else
                fdata_q[wptr_q] <= buf_data;
`endif
                ffeat_q[wptr_q] <= fly_feat_q;
                frow_q[wptr_q]  <= fly_row_q;
                flast_q[wptr_q] <= fly_last_q;
                wptr_q          <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            cnt_q <= cnt_q + {1'b0, fly_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_conv1_row_sequencer.sv
// Scoreboard bench for conv1_row_sequencer: a buffer model returns random rows,
// expected rows/addresses are queued per pass and checked by a monitor.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_conv1_row_sequencer;
    localparam int IS = 12, TF = 20, AW = 12;
    localparam int DW = IS * `DATA_WIDTH;
`ifdef CONV1_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int ROWS = IS + (PAD ? 4 : 0);

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] buf_data = '0;
    logic          buf_rd, out_valid, out_last, busy, done;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] out_data;
    logic [4:0]    out_feature, out_row;

    always #5 clk = ~clk;

    conv1_row_sequencer #(.INPUT_SIZE(IS), .TOTAL_FEATURE(TF), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .buf_rd(buf_rd), .buf_addr(buf_addr), .buf_data(buf_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_feature(out_feature), .out_row(out_row), .out_last(out_last),
        .busy(busy), .done(done));

    typedef struct packed {
        logic [DW-1:0] data;
        logic [4:0]    feat;
        logic [4:0]    row;
        logic          last;
    } row_t;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    row_t          exp_q[$];
    int            addr_q[$];
    int            vectors = 0, errors = 0, cyc = 0;
    int            rd_cnt = 0, hs_cnt = 0, pass_hs = 0, done_cnt = 0, last_hs_cyc = -10;
    int            ready_mode = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_reset();
        chk("rst_buf_rd", buf_rd, 0);
        chk("rst_buf_addr", buf_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_feature", out_feature, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    // Reference: every feature, every row in order; pad rows are zero, buffer
    // rows come from address feature*IS + (row - leading pad)
    task automatic start_pass();
        for (int f = 0; f < TF; f++)
            for (int r = 0; r < ROWS; r++) begin
                row_t e;
                int   br;
                br     = PAD ? r - 2 : r;
                e.feat = 5'(f);
                e.row  = 5'(r);
                e.last = (f == TF - 1) && (r == ROWS - 1);
                if (br < 0 || br >= IS) e.data = '0;
                else begin
                    e.data = mem[f * IS + br];
                    addr_q.push_back(f * IS + br);
                end
                exp_q.push_back(e);
            end
        pass_hs = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int k = 0;
        while (pass_hs < n && k < 5000) begin @(posedge clk); k++; end
        chk("wait_rows_timeout", pass_hs >= n, 1);
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < 5000) begin @(posedge clk); k++; end
        chk("done_seen", done_cnt != d0, 1);
        repeat (6) @(posedge clk);
        chk("one_done", done_cnt - d0, 1);
        chk("queue_empty", exp_q.size(), 0);
        chk("addr_queue_empty", addr_q.size(), 0);
    endtask

    // Buffer model: data valid the cycle after a read strobe, garbage otherwise
    initial begin
        logic          r;
        logic [AW-1:0] a;
        forever begin
            @(negedge clk);
            r = buf_rd;
            a = buf_addr;
            @(posedge clk);
            #1;
            buf_data = r ? mem[a] : {DW/32{$urandom}};
        end
    end

    // Downstream ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: addresses, occupancy bound, hold-during-stall, scoreboard, done timing
    initial begin
        logic          prev_stall = 1'b0;
        logic [106:0]  prev_out = '0;
        row_t          e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin prev_stall = 1'b0; continue; end
            if (buf_rd) begin
                if (addr_q.size() == 0) chk("spurious_rd", 1, 0);
                else chk("rd_addr", buf_addr, addr_q.pop_front());
                rd_cnt++;
            end
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {out_data, out_feature, out_row, out_last}, prev_out);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_row", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("row_data", out_data, e.data);
                    chk("row_tag", {out_feature, out_row, out_last}, {e.feat, e.row, e.last});
                end
                hs_cnt++;
                pass_hs++;
                if (out_last) last_hs_cyc = cyc;
            end
            chk("occupancy", (rd_cnt - hs_cnt) <= 2, 1);
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_data, out_feature, out_row, out_last};
            if (done) begin
                chk("done_timing", cyc, last_hs_cyc + 1);
                chk("busy_at_done", busy, 0);
                done_cnt++;
            end
        end
    end

    initial begin
        int k, fv;
        for (int i = 0; i < (1 << AW); i++) begin
            logic [DW-1:0] w = '0;
            for (int j = 0; j < (DW + 31) / 32; j++) w = (w << 32) | DW'($urandom);
            mem[i] = w;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full-rate pass: latency, throughput, done timing
        ready_mode = 0;
        start_pass();
        k = 0;
        while (k < 20) begin
            @(posedge clk); #1;
            k++;
            if (out_valid) break;
        end
        chk("first_valid_latency", k, 2);
        fv = cyc + 1;
        wait_done();
        chk("throughput", last_hs_cyc - fv, ROWS * TF - 1);

        // Ready toggling every cycle
        ready_mode = 1;
        start_pass();
        wait_done();

        // Long stall in the middle of feature 7
        ready_mode = 0;
        start_pass();
        wait_hs(7 * ROWS + 4);
        ready_mode = 3;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (i >= 3) chk("stall_no_rd", buf_rd, 0);
        end
        ready_mode = 0;
        wait_done();

        // Reset mid-pass at feature 10 row 5, then a fresh pass with random ready
        ready_mode = 2;
        start_pass();
        wait_hs(10 * ROWS + 5);
        k = done_cnt;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        exp_q.delete();
        addr_q.delete();
        rd_cnt = 0;
        hs_cnt = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        chk("no_done_after_abort", done_cnt, k);
        start_pass();
        wait_done();

        // Start pulses while busy are ignored
        ready_mode = 0;
        start_pass();
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        chk("idle_after_pass", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
